// File: rtl/as_pipe_unit.sv
// Pipelined add/sub unit: wrapping or signed-saturating arithmetic with {carry, overflow, zero, negative} flags.
// Latency: STAGES cycles from the accepting edge; one beat per cycle sustained when the output is not stalled.
// Backpressure: a single advance enable freezes every stage while out_valid && !out_ready; in_ready mirrors it.
module as_pipe_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  // One pipeline payload: final result plus {carry, overflow, zero, negative}.
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
  } beat_t;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             adv;
  logic             is_sub;
  logic             is_sat;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] fin;
  beat_t            calc_dat;

  logic             stg_vld [STAGES];
  beat_t            stg_dat [STAGES];

  // The whole pipe moves together: only a held, unaccepted output beat stops it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage-1 arithmetic: subtraction is op1 + ~op2 + 1 on a WIDTH+1-bit sum.
  always_comb begin
    is_sub = mode[0];
    is_sat = mode[1];
    opb    = is_sub ? ~op2 : op2;
    sum    = {1'b0, op1} + {1'b0, opb} + {{WIDTH{1'b0}}, is_sub};
    // For subtraction the carry-out is "no borrow", so invert it to report the borrow.
    carry  = is_sub ? ~sum[WIDTH] : sum[WIDTH];
    // Signed overflow: both addends share a sign that the wrapped sum does not.
    ovf    = (op1[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
    fin    = sum[WIDTH-1:0];
    if (is_sat && ovf) begin
      fin = op1[WIDTH-1] ? SMIN : SMAX;
    end
    calc_dat.res = fin;
    calc_dat.flg = {carry, ovf, (fin == '0), fin[WIDTH-1]};
  end

  // Stage registers: load stage 1 from the operands, shift the rest forward on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_vld[i] <= 1'b0;
        stg_dat[i] <= '0;
      end
    end else if (adv) begin
      stg_vld[0] <= in_valid;
      // Bubbles carry a zero payload so idle operand values never reach the output.
      stg_dat[0] <= in_valid ? calc_dat : '0;
      for (int i = 1; i < STAGES; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_dat[i] <= stg_dat[i-1];
      end
    end
  end

  assign out_valid = stg_vld[STAGES-1];
  assign result    = stg_dat[STAGES-1].res;
  assign flags     = stg_dat[STAGES-1].flg;

endmodule

// File: tb/tb_as_pipe_unit.sv
// Directed bench for as_pipe_unit: a 32-bit/2-stage instance plus 8-bit 1-stage and 4-stage instances.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge (or 1ns after it).
// Flags are {carry, overflow, zero, negative}.
module tb_as_pipe_unit;

  logic        clk = 1'b0;
  logic        rst;
  int          compared = 0;
  int          mismatched = 0;

  // 32-bit, 2-stage instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  mode;
  logic [31:0] op1, op2, result;
  logic [3:0]  flags;

  // 8-bit instances share their inputs
  logic        in_valid8, out_ready8;
  logic [1:0]  mode8;
  logic [7:0]  a8, b8;
  logic        in_ready_s1, out_valid_s1, in_ready_s4, out_valid_s4;
  logic [7:0]  result_s1, result_s4;
  logic [3:0]  flags_s1, flags_s4;

  always #5 clk = ~clk;

  as_pipe_unit #(.WIDTH(32), .STAGES(2)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  as_pipe_unit #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_s1), .mode(mode8),
    .op1(a8), .op2(b8), .out_valid(out_valid_s1), .out_ready(out_ready8),
    .result(result_s1), .flags(flags_s1)
  );

  as_pipe_unit #(.WIDTH(8), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_s4), .mode(mode8),
    .op1(a8), .op2(b8), .out_valid(out_valid_s4), .out_ready(out_ready8),
    .result(result_s4), .flags(flags_s4)
  );

  task automatic test_reset();
    logic seen;
    rst = 1'b1; in_valid = 1'b1; mode = 2'b00; op1 = 32'd1; op2 = 32'd1; out_ready = 1'b0;
    in_valid8 = 1'b1; mode8 = 2'b00; a8 = 8'd1; b8 = 8'd1; out_ready8 = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    compared++; if (result !== 32'h0) begin mismatched++; $display("FAIL reset_result got=%h exp=0", result); end
    compared++; if (flags !== 4'b0000) begin mismatched++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    compared++; if ({out_valid_s1, out_valid_s4} !== 2'b00) begin mismatched++; $display("FAIL reset_out_valid8 got=%b exp=00", {out_valid_s1, out_valid_s4}); end
    in_valid = 1'b0; in_valid8 = 1'b0; rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || out_valid_s1 || out_valid_s4) seen = 1'b1;
    end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL reset_no_output got=%b exp=0", seen); end
  endtask

  // Single beat through the 32-bit unit with no stall; checks latency, result, flags.
  task automatic op32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [3:0] ef, input string nm);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; mode = m; op1 = a; op2 = b; out_ready = 1'b1;
    @(negedge clk);
    // Scramble operands after acceptance; they must have no effect.
    in_valid = 1'b0; mode = ~m; op1 = ~a; op2 = 32'h1234_5678;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    compared++; if (lat !== 2) begin mismatched++; $display("FAIL %s_latency got=%0d exp=2", nm, lat); end
    compared++; if (result !== er) begin mismatched++; $display("FAIL %s_result got=%h exp=%h", nm, result, er); end
    compared++; if (flags !== ef) begin mismatched++; $display("FAIL %s_flags got=%b exp=%b", nm, flags, ef); end
  endtask

  task automatic test_wrap_add();
    op32(2'b00, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000, "add_1_1");
    op32(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, "add_carry_zero");
    op32(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, "add_wrap_ovf");
  endtask

  task automatic test_wrap_sub();
    op32(2'b01, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 4'b0000, "sub_5_3");
    op32(2'b01, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b1001, "sub_borrow");
  endtask

  task automatic test_saturate();
    op32(2'b10, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0100, "sadd_pos_clamp");
    op32(2'b11, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 4'b0101, "ssub_neg_clamp");
    op32(2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b1101, "sadd_neg_clamp_carry");
    op32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1001, "sadd_no_clamp");
    op32(2'b11, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 4'b0000, "ssub_no_clamp");
  endtask

  task automatic test_backpressure();
    int sent;
    int got;
    int stall_checks;
    logic [31:0] prev_res;
    logic stalled_prev;
    logic seen;
    sent = 0; got = 0; stall_checks = 0; stalled_prev = 1'b0; prev_res = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (sent < 6) begin
        in_valid = 1'b1; mode = 2'b00; op1 = 32'(sent + 1); op2 = 32'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && out_valid) begin
        stall_checks++;
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready_stall cyc=%0d got=%b exp=0", cyc, in_ready); end
        if (stalled_prev) begin
          compared++; if (result !== prev_res) begin mismatched++; $display("FAIL bp_result_hold cyc=%0d got=%h exp=%h", cyc, result, prev_res); end
        end
      end
      stalled_prev = !out_ready && out_valid;
      prev_res = result;
      if (out_valid && out_ready) begin
        compared++; if (result !== 32'(2 * (got + 1))) begin mismatched++; $display("FAIL bp_result_%0d got=%0d exp=%0d", got, result, 2 * (got + 1)); end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    compared++; if (got !== 6) begin mismatched++; $display("FAIL bp_count got=%0d exp=6", got); end
    compared++; if (stall_checks !== 3) begin mismatched++; $display("FAIL bp_stall_cycles got=%0d exp=3", stall_checks); end
    in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL bp_no_duplicate got=%b exp=0", seen); end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'b00; op1 = 32'd100; op2 = 32'd1;
    in_valid8 = 1'b1; mode8 = 2'b00; a8 = 8'd3; b8 = 8'd4; out_ready8 = 1'b1;
    @(negedge clk);
    op1 = 32'd200; a8 = 8'd5;
    @(negedge clk);
    // Beat A is presented but not taken; beat B sits behind it.
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL flush_inflight got=%b exp=1", out_valid); end
    in_valid = 1'b0; in_valid8 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    compared++; if (result !== 32'h0) begin mismatched++; $display("FAIL flush_result got=%h exp=0", result); end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || out_valid_s4) seen = 1'b1;
    end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL flush_no_output got=%b exp=0", seen); end
  endtask

  // Single beat into both 8-bit units; latency must equal each unit's STAGES.
  task automatic op8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] er, input logic [3:0] ef, input string nm);
    int ls1;
    int ls4;
    logic [7:0] r1, r4;
    logic [3:0] f1, f4;
    ls1 = 0; ls4 = 0; r1 = '0; r4 = '0; f1 = '0; f4 = '0;
    @(negedge clk);
    in_valid8 = 1'b1; mode8 = m; a8 = a; b8 = b; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = ~a; b8 = 8'h5A;
    for (int c = 1; c <= 10; c++) begin
      if (ls1 == 0 && out_valid_s1) begin ls1 = c; r1 = result_s1; f1 = flags_s1; end
      if (ls4 == 0 && out_valid_s4) begin ls4 = c; r4 = result_s4; f4 = flags_s4; end
      if (ls1 != 0 && ls4 != 0) break;
      @(negedge clk);
    end
    compared++; if (ls1 !== 1) begin mismatched++; $display("FAIL %s_s1_latency got=%0d exp=1", nm, ls1); end
    compared++; if (ls4 !== 4) begin mismatched++; $display("FAIL %s_s4_latency got=%0d exp=4", nm, ls4); end
    compared++; if (r1 !== er) begin mismatched++; $display("FAIL %s_s1_result got=%h exp=%h", nm, r1, er); end
    compared++; if (r4 !== er) begin mismatched++; $display("FAIL %s_s4_result got=%h exp=%h", nm, r4, er); end
    compared++; if (f1 !== ef) begin mismatched++; $display("FAIL %s_s1_flags got=%b exp=%b", nm, f1, ef); end
    compared++; if (f4 !== ef) begin mismatched++; $display("FAIL %s_s4_flags got=%b exp=%b", nm, f4, ef); end
  endtask

  task automatic test_param_sweep();
    op8(2'b10, 8'h7F, 8'h01, 8'h7F, 4'b0100, "w8_sadd_clamp");
    op8(2'b00, 8'h7F, 8'h01, 8'h80, 4'b0101, "w8_add_wrap");
    op8(2'b00, 8'hFF, 8'h01, 8'h00, 4'b1010, "w8_add_carry");
    op8(2'b01, 8'h01, 8'h02, 8'hFF, 4'b1001, "w8_sub_borrow");
    op8(2'b11, 8'h80, 8'h01, 8'h80, 4'b0101, "w8_ssub_clamp");
  endtask

  initial begin
    test_reset();
    test_wrap_add();
    test_wrap_sub();
    test_saturate();
    test_backpressure();
    test_flush();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached compared=%0d", compared);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/as_pipe_unit.md
# as_pipe_unit

Parametrised, pipelined add/subtract unit with a valid/ready handshake on both sides, selectable wrapping or signed-saturating arithmetic, and a full flag set. It succeeds the single-cycle registered add/sub block in the RISC-V execute path. Sustained throughput is one operation per cycle at a configurable latency, so the unit can sit between the operand-fetch and writeback stages and absorb writeback stalls without losing results.

## Interface
- WIDTH, 32: operand and result width in bits; legal range 8..64.
- STAGES, 2: pipeline depth in register stages, equal to the latency in cycles; legal range 1..4.
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- mode  input  2  operation select: 00 add, 01 sub, 10 signed-saturating add, 11 signed-saturating sub.
- op1  input  WIDTH  first operand.
- op2  input  WIDTH  second operand.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  arithmetic result.
- flags  output  4  {carry, overflow, zero, negative}.

## Operation
- Reset is synchronous and active-high on clk, as fixed for this block.
- Beat acceptance: a beat is accepted on a rising edge where in_valid && in_ready.
- Arithmetic is done in stage 1 on a WIDTH+1-bit sum.
  - Sub is computed as op1 + ~op2 + 1.
- Stages 2..STAGES only carry the result, flags and a valid bit forward.
- carry:
  - add and sat-add: the unsigned carry-out of bit WIDTH-1.
  - sub and sat-sub: the borrow, i.e. 1 when op1 < op2 unsigned.
- overflow: signed overflow of the wrapping result, in all four modes.
- Saturating modes, when overflow is 1:
  - Result clamps to 2^(WIDTH-1)-1 if op1 is non-negative.
  - Otherwise it clamps to -2^(WIDTH-1).
  - overflow stays 1; carry still reflects the unclamped operation.
- Wrapping modes never clamp; the result is the low WIDTH bits.
- zero and negative are taken from the final (post-clamp) result: result == 0 and result[WIDTH-1].
- Stall control uses a single enable, adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - When adv=1, every stage shifts forward by one.
  - When adv=0, every stage holds.
- Bubbles (invalid stages) propagate through; they are not collapsed while the output is stalled.
- Ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Reset values: out_valid=0, result=0, flags=0, all internal valid bits 0. in_ready=1 in the first cycle after reset.
- Reset mid-operation flushes every in-flight beat. Beats accepted before the reset edge are never output.
- Latency: a beat accepted at edge N with no stall appears with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following edge N+STAGES-1. With STAGES=1 it is visible one cycle after acceptance.
- Throughput: with out_ready held at 1, one beat per cycle, continuously.
- While out_valid=1 and out_ready=0:
  - result and flags are held stable.
  - in_ready=0.
  - The upstream must hold its beat.
- If out_valid && out_ready and in_valid occur in the same cycle, the output beat retires and the new beat enters on that edge.
- mode, op1 and op2 are sampled only on an accepting edge. Their values at any other time have no effect.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, result=0, flags=0; no output appears after release.
- Wrapping add, WIDTH=32, STAGES=2: 0x00000001+0x00000001 -> result 0x00000002, flags 0000 after 2 cycles. 0xFFFFFFFF+0x00000001 -> result 0x00000000, carry=1, zero=1, overflow=0.
- Wrapping sub: 0x00000005-0x00000003 -> 0x00000002, flags 0000. 0x00000001-0x00000002 -> 0xFFFFFFFF, carry(borrow)=1, negative=1, overflow=0.
- Saturating modes:
  - mode 10, 0x7FFFFFFF+0x00000001 -> 0x7FFFFFFF, overflow=1.
  - mode 11, 0x80000000-0x00000001 -> 0x80000000, overflow=1, negative=1.
  - mode 00, 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow=1.
- Backpressure: stream 6 back-to-back adds (k+k, k=1..6) and hold out_ready=0 for 3 cycles mid-stream -> results 2,4,6,8,10,12 in order, none lost or repeated; result stable while stalled; in_ready=0 during the stall.
- Flush and parameter sweep: reset asserted with 2 beats in flight -> neither beat emerges. Repeat the add/sub scenarios at WIDTH=8 with STAGES=1 and STAGES=4: 0x7F+0x01 in mode 10 -> 0x7F; latency equals STAGES.
